// File: rtl/asym_fifo_read_wider_if.sv
// Bus bundle for the asymmetric FIFO: narrow write side, wide read side,
// occupancy and error flags. The master drives requests; the FIFO is the slave.
interface asym_fifo_read_wider_if #(
  parameter int AW  = 10,
  parameter int DWW = 4,
  parameter int DWR = 16
);
  logic           wr_en;
  logic [DWW-1:0] wr_data;
  logic           full;
  logic           rd_en;
  logic [DWR-1:0] rd_data;
  logic           rd_valid;
  logic           empty;
  logic [AW:0]    count;
  logic           overflow;
  logic           underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, rd_valid, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, rd_valid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/asym_fifo_read_wider.sv
// Single-clock FIFO that accepts DWW-bit words and releases DWR-bit words,
// RATIO = DWR/DWW narrow words per read, little-endian lane order.
// Optional feature macro: ASYM_FIFO_ERR_FLAGS_EN enables sticky
// overflow/underflow flags; without it both flags are tied to 0.
module asym_fifo_read_wider #(
  parameter int AW  = 10,
  parameter int DWW = 4,
  parameter int DWR = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  asym_fifo_read_wider_if.slave  bus
);
  localparam int DEPTH = 1 << AW;
  localparam int RATIO = DWR / DWW;

  logic [DWW-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_q;
  logic [DWR-1:0] rd_word;
  logic [DWR-1:0] rd_data_q;
  logic           rd_valid_q;
  logic           full_w;
  logic           empty_w;
  logic           wr_acc;
  logic           rd_acc;

  // A read needs a whole wide word available; a write is refused only when
  // every narrow slot is occupied, so a full FIFO still serves reads.
  assign full_w  = (count_q == (AW+1)'(DEPTH));
  assign empty_w = (count_q < (AW+1)'(RATIO));
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  // Gather RATIO consecutive narrow words; rd_ptr is RATIO-aligned so OR-ing
  // the lane index never carries and the group never straddles the wrap.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      rd_word[k*DWW +: DWW] = mem[rd_ptr | AW'(k)];
    end
  end

  // Storage write; an accepted write only ever lands in the free region.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointer and occupancy bookkeeping, simultaneous push/pop in one step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(RATIO);
      end
      count_q <= count_q + (AW+1)'(wr_acc) - (rd_acc ? (AW+1)'(RATIO) : '0);
    end
  end

  // Registered read port: data and valid pulse one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= rd_word;
      end
    end
  end

`ifdef ASYM_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags for requests made against a full or empty FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_asym_fifo_read_wider.sv
// Self-checking bench for asym_fifo_read_wider (AW=4, DWW=4, DWR=16).
// A queue-based model tracks the FIFO contents; every cycle the DUT outputs
// are compared with it, and directed scenarios pin literal values.
module tb_asym_fifo_read_wider;
  localparam int AW  = 4;
  localparam int DWW = 4;
  localparam int DWR = 16;

`ifdef ASYM_FIFO_ERR_FLAGS_EN
  localparam logic FLAG_ON = 1'b1;
`else
  localparam logic FLAG_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  asym_fifo_read_wider_if #(.AW(AW), .DWW(DWW), .DWR(DWR)) bus ();

  asym_fifo_read_wider #(.AW(AW), .DWW(DWW), .DWR(DWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DWW-1:0] mq[$];
  logic           exp_valid = 1'b0;
  logic [DWR-1:0] exp_data = '0;
  logic           exp_ovf = 1'b0;
  logic           exp_udf = 1'b0;
  bit             model_live = 0;

  logic [15:0] pat [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
  int reads = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [DWW-1:0] wd, input logic rd);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: the FIFO as a plain queue of narrow words.
  always @(posedge clk) begin
    int  n;
    bit  wr_ok;
    bit  rd_ok;
    if (!rst_n) begin
      mq.delete();
      exp_valid  = 1'b0;
      exp_data   = '0;
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
      model_live = 1;
    end else if (model_live) begin
      n     = mq.size();
      wr_ok = bus.wr_en && (n < 16);
      rd_ok = bus.rd_en && (n >= 4);
      if (FLAG_ON && bus.wr_en && n == 16) exp_ovf = 1'b1;
      if (FLAG_ON && bus.rd_en && n < 4)   exp_udf = 1'b1;
      exp_valid = rd_ok;
      if (rd_ok) begin
        for (int k = 0; k < 4; k++) exp_data[k*4 +: 4] = mq.pop_front();
      end
      if (wr_ok) mq.push_back(bus.wr_data);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("count",     32'(bus.count),  32'(mq.size()));
      checkOutput("full",      32'(bus.full),   32'(mq.size() == 16));
      checkOutput("empty",     32'(bus.empty),  32'(mq.size() < 4));
      checkOutput("rd_valid",  32'(bus.rd_valid), 32'(exp_valid));
      checkOutput("rd_data",   32'(bus.rd_data),  32'(exp_data));
      checkOutput("overflow",  32'(bus.overflow),  32'(exp_ovf));
      checkOutput("underflow", 32'(bus.underflow), 32'(exp_udf));
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Reset state
    checkOutput("rst_count", 32'(bus.count), 0);
    checkOutput("rst_empty", 32'(bus.empty), 1);
    checkOutput("rst_full", 32'(bus.full), 0);
    checkOutput("rst_valid", 32'(bus.rd_valid), 0);
    checkOutput("rst_data", 32'(bus.rd_data), 0);
    checkOutput("rst_ovf", 32'(bus.overflow), 0);
    checkOutput("rst_udf", 32'(bus.underflow), 0);
    rst_n = 1'b1;

    // Four narrow words assemble into one little-endian wide word
    applyStimulus(1, 4'h1, 0);
    applyStimulus(1, 4'h2, 0);
    applyStimulus(1, 4'h3, 0);
    applyStimulus(1, 4'h4, 0);
    applyStimulus(0, 0, 1);
    checkOutput("basic_valid", 32'(bus.rd_valid), 1);
    checkOutput("basic_data", 32'(bus.rd_data), 32'h4321);
    checkOutput("basic_count", 32'(bus.count), 0);
    checkOutput("basic_empty", 32'(bus.empty), 1);
    applyStimulus(0, 0, 0);
    checkOutput("basic_valid_drop", 32'(bus.rd_valid), 0);
    checkOutput("basic_data_hold", 32'(bus.rd_data), 32'h4321);

    // Read refused with fewer than RATIO words stored
    applyStimulus(1, 4'hA, 0);
    applyStimulus(1, 4'hB, 0);
    applyStimulus(1, 4'hC, 0);
    applyStimulus(0, 0, 1);
    checkOutput("short_valid", 32'(bus.rd_valid), 0);
    checkOutput("short_count", 32'(bus.count), 3);
    checkOutput("short_empty", 32'(bus.empty), 1);
    checkOutput("short_udf", 32'(bus.underflow), 32'(FLAG_ON));

    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    rst_n = 1'b1;

    // Fill to capacity, then an extra write is dropped
    for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 0);
    checkOutput("fill_full", 32'(bus.full), 1);
    checkOutput("fill_count", 32'(bus.count), 16);
    applyStimulus(1, 4'h5, 0);
    checkOutput("over_count", 32'(bus.count), 16);
    checkOutput("over_ovf", 32'(bus.overflow), 32'(FLAG_ON));

    // Full FIFO with write and read together: only the read goes through
    applyStimulus(1, 4'h9, 1);
    checkOutput("fullrw_valid", 32'(bus.rd_valid), 1);
    checkOutput("fullrw_data", 32'(bus.rd_data), 32'h3210);
    checkOutput("fullrw_count", 32'(bus.count), 12);
    checkOutput("fullrw_full", 32'(bus.full), 0);
    checkOutput("fullrw_ovf", 32'(bus.overflow), 32'(FLAG_ON));
    applyStimulus(0, 0, 1);
    checkOutput("next_data", 32'(bus.rd_data), 32'h7654);
    checkOutput("next_count", 32'(bus.count), 8);

    // Reset in mid-operation overrides a concurrent write
    rst_n = 1'b0;
    applyStimulus(1, 4'h9, 0);
    checkOutput("midrst_count", 32'(bus.count), 0);
    checkOutput("midrst_empty", 32'(bus.empty), 1);
    checkOutput("midrst_full", 32'(bus.full), 0);
    checkOutput("midrst_valid", 32'(bus.rd_valid), 0);
    checkOutput("midrst_ovf", 32'(bus.overflow), 0);
    checkOutput("midrst_udf", 32'(bus.underflow), 0);
    rst_n = 1'b1;

    // Streaming across the pointer wrap: 40 words, read whenever possible
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 4'(i), mq.size() >= 4);
      if (bus.rd_valid) begin
        checkOutput("wrap_data", 32'(bus.rd_data), 32'(pat[reads % 4]));
        reads++;
      end
    end
    repeat (12) begin
      applyStimulus(0, 0, mq.size() >= 4);
      if (bus.rd_valid) begin
        checkOutput("wrap_data", 32'(bus.rd_data), 32'(pat[reads % 4]));
        reads++;
      end
    end
    checkOutput("wrap_reads", 32'(reads), 10);
    checkOutput("wrap_count", 32'(bus.count), 0);

    // Randomized traffic with alternating fill/drain bias and rare resets
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 300; i++) begin
        rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        if (seg % 2 == 0)
          applyStimulus($urandom_range(0, 99) < 90, 4'($urandom), $urandom_range(0, 99) < 12);
        else
          applyStimulus($urandom_range(0, 99) < 50, 4'($urandom), $urandom_range(0, 99) < 45);
      end
    end
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
